// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned RD_W      = 5;
    localparam int unsigned OP_W      = 4;

    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] SIGN_MIN = {1'b1, {(XLEN-1){1'b0}}};

    // bit3 = valid, bit2 = divide, bits1:0 = funct3[1:0]
    typedef enum logic [OP_W-1:0] {
        OP_MUL    = 4'b1000,
        OP_MULH   = 4'b1001,
        OP_MULHSU = 4'b1010,
        OP_MULHU  = 4'b1011,
        OP_DIV    = 4'b1100,
        OP_DIVU   = 4'b1101,
        OP_REM    = 4'b1110,
        OP_REMU   = 4'b1111
    } muldiv_op_t;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DONE
    } muldiv_state_t;

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? XLEN'(-x) : x;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// One restoring radix-2 division step: shift in the next dividend bit, trial-subtract.
module div_iter
    import muldiv_pkg::*;
(
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_c,
    output logic [XLEN-1:0] quo_c
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;

    // Quotient register doubles as the dividend shifter; its MSB feeds the remainder.
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {2'b00, divisor_i};
        if (diff[XLEN+1]) begin
            rem_c = shifted[XLEN:0];
            quo_c = {quo_i[XLEN-2:0], 1'b0};
        end else begin
            rem_c = diff[XLEN:0];
            quo_c = {quo_i[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: single-cycle multiply, 32-step restoring divide,
// busy stall toward issue and a one-cycle done pulse toward commit.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            nrst,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [OP_W-1:0] mulDiv_op,
    input  logic [RD_W-1:0] rd,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [RD_W-1:0] rd_out,
    output logic            we_out
);

    muldiv_state_t   state_q, state_d;
    logic [XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]      funct_q, funct_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [RD_W-1:0] rd_out_q, rd_out_d;
    logic            we_q, we_d;

    logic [XLEN:0]     rem_step;
    logic [XLEN-1:0]   quo_step;
    logic              a_sext, b_sext;
    logic [2*XLEN-1:0] prod;
    logic              in_signed;
    logic              in_div_zero;
    logic              in_overflow;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    div_iter u_div_iter (
        .rem_i     (rem_q),
        .quo_i     (opa_q),
        .divisor_i (opb_q),
        .rem_c     (rem_step),
        .quo_c     (quo_step)
    );

    // Multiply via 64-bit product of sign/zero-extended operands; low 64 bits are exact.
    always_comb begin
        a_sext = (funct_q != 2'b11) & opa_q[XLEN-1];
        b_sext = ~funct_q[1] & opb_q[XLEN-1];
        prod   = {{XLEN{a_sext}}, opa_q} * {{XLEN{b_sext}}, opb_q};
    end

    always_comb begin
        in_signed   = ~mulDiv_op[0];
        in_div_zero = (op_b == '0);
        in_overflow = in_signed && (op_a == SIGN_MIN) && (op_b == ALL_ONES);
        quo_fix     = neg_quo_q ? XLEN'(-opa_q) : opa_q;
        rem_fix     = neg_rem_q ? XLEN'(-rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
    end

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        funct_d   = funct_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rd_d      = rd_q;
        result_d  = result_q;

        if (kill) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mulDiv_op[3]) begin
                        funct_d = mulDiv_op[1:0];
                        rd_d    = rd;
                        if (!mulDiv_op[2]) begin
                            opa_d   = op_a;
                            opb_d   = op_b;
                            state_d = MUL;
                        end else if (in_div_zero) begin
                            result_d = mulDiv_op[1] ? op_a : ALL_ONES;
                            state_d  = DONE;
                        end else if (in_overflow) begin
                            result_d = mulDiv_op[1] ? '0 : SIGN_MIN;
                            state_d  = DONE;
                        end else begin
                            opa_d     = in_signed ? abs_val(op_a) : op_a;
                            opb_d     = in_signed ? abs_val(op_b) : op_b;
                            rem_d     = '0;
                            cnt_d     = CNT_W'(DIV_ITERS - 1);
                            neg_quo_d = in_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
                            neg_rem_d = in_signed & op_a[XLEN-1];
                            state_d   = DIV;
                        end
                    end
                end
                MUL: begin
                    result_d = (funct_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    state_d  = DONE;
                end
                DIV: begin
                    rem_d = rem_step;
                    opa_d = quo_step;
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                FIX: begin
                    result_d = funct_q[1] ? rem_fix : quo_fix;
                    state_d  = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Outputs are registered off the next state so they line up with it.
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        rd_out_d = done_d ? rd_d : rd_out_q;
        we_d     = done_d && (rd_d != '0);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            funct_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rd_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            rd_out_q  <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            funct_q   <= funct_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rd_q      <= rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
            we_q      <= we_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_out_q;
    assign we_out = we_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, kill, reset and busy-ignore.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        nrst;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  mul_div_op;
    logic [4:0]  rd;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        we_out;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit dut (
        .clk       (clk),
        .nrst      (nrst),
        .op_a      (op_a),
        .op_b      (op_b),
        .mulDiv_op (mul_div_op),
        .rd        (rd),
        .kill      (kill),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out),
        .we_out    (we_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the op is accepted at the next rising edge (end of cycle T).
    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] r);
        mul_div_op = op;
        op_a       = a;
        op_b       = b;
        rd         = r;
        @(posedge clk);
        #1;
        mul_div_op = 4'b0000;
    endtask

    // Waits for done (bounded), checks latency and outputs, then the idle cycle after it.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r,
                          input int lat, input logic [31:0] exp);
        int  n;
        bit  got;
        bit  busy_ok;
        n       = 99;
        got     = 1'b0;
        busy_ok = 1'b1;
        start_op(op, a, b, r);
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                got = 1'b1;
                n   = i;
            end
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " result"}, result, exp);
        check({tag, " rd_out"}, 32'(rd_out), 32'(r));
        check({tag, " we_out"}, 32'(we_out), 32'(r != 5'd0));
        check({tag, " busy held"}, 32'(busy_ok), 32'd1);
        @(negedge clk);
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " busy after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int  n;
        bit  got;
        bit  quiet;

        nrst       = 1'b0;
        op_a       = '0;
        op_b       = '0;
        mul_div_op = '0;
        rd         = '0;
        kill       = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset we_out", 32'(we_out), 32'd0);
        check("reset result", result, 32'd0);
        check("reset rd_out", 32'(rd_out), 32'd0);
        nrst = 1'b1;
        @(negedge clk);

        run_op("MUL",    OP_MUL,    32'd7,        32'hFFFF_FFFD, 5'd5, 2, 32'hFFFF_FFEB);
        run_op("MULHU",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 2, 32'hFFFF_FFFE);
        run_op("MULH",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 2, 32'h0000_0000);
        run_op("MULHSU", OP_MULHSU, 32'hFFFF_FFFF, 32'd2,        5'd3, 2, 32'hFFFF_FFFF);

        run_op("DIV",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd9,  34, 32'hFFFF_FFFD);
        run_op("REM",  OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd10, 34, 32'hFFFF_FFFF);
        run_op("DIVU", OP_DIVU, 32'd100,       32'd7, 5'd11, 34, 32'd14);
        run_op("REMU", OP_REMU, 32'd100,       32'd7, 5'd12, 34, 32'd2);

        run_op("DIVU by 0", OP_DIVU, 32'd5, 32'd0, 5'd13, 1, 32'hFFFF_FFFF);
        run_op("REM by 0",  OP_REM,  32'd5, 32'd0, 5'd14, 1, 32'd5);
        run_op("DIV ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1, 32'h8000_0000);
        run_op("REM ovf",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1, 32'h0000_0000);

        // Back-to-back: divide, then multiply to x0 accepted the cycle after done.
        run_op("b2b DIVU", OP_DIVU, 32'd1000, 32'd3, 5'd17, 34, 32'd333);
        run_op("b2b MUL x0", OP_MUL, 32'd6, 32'd9, 5'd0, 2, 32'd54);

        // Kill in cycle T+10 of a divide, then a multiply accepted at T+11.
        start_op(OP_DIV, 32'd1000, 32'd3, 5'd7);
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill busy", 32'(busy), 32'd0);
        check("kill done", 32'(done), 32'd0);
        run_op("MUL after kill", OP_MUL, 32'd6, 32'd7, 5'd8, 2, 32'd42);

        // A multiply presented while a divide is busy must be ignored.
        start_op(OP_DIVU, 32'd100, 32'd7, 5'd3);
        @(negedge clk);
        @(negedge clk);
        mul_div_op = OP_MUL;
        op_a       = 32'd9;
        op_b       = 32'd9;
        rd         = 5'd4;
        @(negedge clk);
        mul_div_op = 4'b0000;
        n   = 99;
        got = 1'b0;
        for (int i = 4; i <= 40 && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                n   = i;
            end
        end
        check("ignore latency", 32'(n), 32'd34);
        check("ignore result", result, 32'd14);
        check("ignore rd_out", 32'(rd_out), 32'd3);
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check("ignore no second op", 32'(quiet), 32'd1);

        // Asynchronous reset in the middle of a divide.
        start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6);
        repeat (5) @(negedge clk);
        nrst = 1'b0;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst we_out", 32'(we_out), 32'd0);
        check("rst result", result, 32'd0);
        check("rst rd_out", 32'(rd_out), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        check("rst op lost", 32'(quiet), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage. It consumes the operands, `mulDiv_op` and `rd` produced by the issue stage. It holds `busy` high to stall the front of the pipeline while an operation is in flight, and presents a single-cycle `done` with the result and destination toward commit.

## Interface
Parameters:
- none (fixed RV32M; XLEN = 32)

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- op_a  in  32  operand A (rs1 value) from issue
- op_b  in  32  operand B (rs2 value) from issue
- mulDiv_op  in  4  operation code:
  - bit3 = valid, bit2 = divide, bits1:0 = funct3[1:0]
  - 1000 MUL, 1001 MULH, 1010 MULHSU, 1011 MULHU
  - 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU
  - 0xxx = no op
- rd  in  5  destination register of the op
- kill  in  1  synchronous flush (exception/discard); aborts any in-flight op
- busy  out  1  unit occupied; stall request to issue/decode
- done  out  1  result valid, one-cycle pulse
- result  out  32  result data, valid when done=1
- rd_out  out  5  captured rd, valid when done=1
- we_out  out  1  register write enable; equals done && rd_out!=0

## Operation
- States:
  - IDLE: accepts new ops.
  - MUL: one compute cycle.
  - DIV: 32 iterations.
  - FIX: sign correction.
  - DONE: result presented.
- Accept: in IDLE with mulDiv_op[3]=1 and kill=0, register operands, op and rd. Next state:
  - MUL for a multiply op.
  - DONE for a special-case divide, with the result precomputed.
  - DIV otherwise.
- Ops presented outside IDLE are ignored; issue holds them via busy.
- Multiply:
  - 33×33 signed product of sign/zero-extended operands. MULH: both signed. MULHSU: A signed, B unsigned. MULHU: both unsigned.
  - MUL returns product[31:0]; the MULH variants return product[63:32].
  - MUL → DONE.
- Divide:
  - Signed ops use |A| and |B|; unsigned ops use the raw operands.
  - Restoring radix-2 over a 33-bit partial remainder, one quotient bit per cycle, with a 5-bit counter from 31 down to 0.
  - DIV → FIX when the counter reaches 0.
  - FIX negates the quotient if sign(A)^sign(B) and negates the remainder if sign(A), for signed ops only. FIX → DONE.
- Special cases, resolved at accept:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- DONE: done=1 for exactly one cycle, then → IDLE.
- busy = (state != IDLE).
- kill: in any state, next state IDLE, counter cleared, done suppressed. Kill has priority over accept in the same cycle.

## Timing
- Reset values:
  - state IDLE
  - busy 0, done 0, we_out 0
  - result 0, rd_out 0
  - internal registers 0
- Reset mid-operation returns to IDLE immediately (asynchronous); the op is lost and no done is produced.
- Accept is at the clock edge ending cycle T.
- Latency to done:
  - Multiply: done in cycle T+2.
  - Normal divide: done in cycle T+34 (32 DIV + 1 FIX + DONE).
  - Special-case divide: done in cycle T+1.
- busy is high from T+1 through the done cycle inclusive. The earliest next accept is in the cycle after done.
- result, rd_out and we_out are registered. They hold their last value when done=0, and consumers ignore them then.
- kill asserted in cycle K: busy=0 and done=0 from K+1. A new op can be accepted at K+1.

## Structure
- Shared package (muldiv_pkg):
  - typedef `muldiv_op_t` holding the 4-bit encodings above.
  - enum `muldiv_state_t` {IDLE, MUL, DIV, FIX, DONE}.
  - constants DIV_ITERS=32, ALL_ONES.
- Sub-module `div_iter`: one restoring-division step (33-bit remainder, quotient shift). It is combinational and instantiated once; the iteration registers stay in muldiv_unit.

## Test plan
- MUL: 7 × 0xFFFFFFFD → result 0xFFFFFFEB, done at T+2, busy at T+1..T+2, we_out=1 for rd=5.
- MULHU: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD and REM −7/2 → 0xFFFFFFFF, each with done at exactly T+34. DIVU 100/7 → 14, REMU → 2.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF at T+1.
  - REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Kill and reset:
  - kill at T+10 of a DIV → no done, busy=0 at T+11; a MUL accepted at T+11 completes at T+13.
  - nrst low mid-divide → all outputs 0 immediately.
- Back-to-back and ignore:
  - DIV then MUL with rd=0 → two done pulses, we_out=0 on the second.
  - An op presented while busy is not executed.
